// File: rtl/axi4lite_master.sv
// AXI4-Lite initiator. Drains a write-request FIFO ({addr,data}) and a
// read-request FIFO (addr), issues one single-beat transaction at a time,
// and pushes read data into a response FIFO. Simultaneous pending requests
// alternate between write and read, starting with write after reset.
module axi4lite_master (
  input  logic        clk,
  input  logic        arest,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        wr_read_en,
  input  logic [63:0] wr_data,
  input  logic        wr_empty,
  output logic        rd_read_en,
  input  logic [31:0] rd_addr,
  input  logic        rd_empty,
  output logic        resp_write_en,
  output logic [31:0] resp_data,
  input  logic        resp_full,
  output logic        wr_err,
  output logic        rd_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t      state, state_n;
  logic        last_was_write, last_was_write_n;

  logic [31:0] awaddr_n, wdata_n, araddr_n, resp_data_n;
  logic        awvalid_n, wvalid_n, bready_n, arvalid_n;
  logic        wr_read_en_n, rd_read_en_n, resp_write_en_n;
  logic        wr_err_n, rd_err_n;

  logic        pick_wr, pick_rd;
  logic        aw_done, w_done;

  // Arbitration: a lone request is served directly; two pending requests
  // alternate based on what was served last.
  assign pick_wr = !wr_empty && (rd_empty || !last_was_write);
  assign pick_rd = !rd_empty && (wr_empty ||  last_was_write);

  // A channel counts as done once its valid has dropped or is being accepted now.
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid  || wready;

  // rready is the only combinational output: never accept data the
  // response FIFO cannot take.
  assign rready = (state == RD_DATA) && !resp_full;

  // Next-state and next-output decode; everything holds unless changed,
  // one-cycle pulses default low.
  always_comb begin
    state_n          = state;
    last_was_write_n = last_was_write;
    awaddr_n         = awaddr;
    awvalid_n        = awvalid;
    wdata_n          = wdata;
    wvalid_n         = wvalid;
    bready_n         = bready;
    araddr_n         = araddr;
    arvalid_n        = arvalid;
    resp_data_n      = resp_data;
    wr_read_en_n     = 1'b0;
    rd_read_en_n     = 1'b0;
    resp_write_en_n  = 1'b0;
    wr_err_n         = 1'b0;
    rd_err_n         = 1'b0;

    case (state)
      IDLE: begin
        if (pick_wr) begin
          awaddr_n         = wr_data[63:32];
          wdata_n          = wr_data[31:0];
          awvalid_n        = 1'b1;
          wvalid_n         = 1'b1;
          wr_read_en_n     = 1'b1;
          last_was_write_n = 1'b1;
          state_n          = WR_REQ;
        end else if (pick_rd) begin
          araddr_n         = rd_addr;
          arvalid_n        = 1'b1;
          rd_read_en_n     = 1'b1;
          last_was_write_n = 1'b0;
          state_n          = RD_REQ;
        end
      end

      WR_REQ: begin
        // AW and W retire independently; address/data are cleared once accepted.
        if (awvalid && awready) begin
          awvalid_n = 1'b0;
          awaddr_n  = 32'h0;
        end
        if (wvalid && wready) begin
          wvalid_n = 1'b0;
          wdata_n  = 32'h0;
        end
        if (aw_done && w_done) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (bvalid && bready) begin
          bready_n = 1'b0;
          wr_err_n = |bresp;
          state_n  = IDLE;
        end
      end

      RD_REQ: begin
        if (arvalid && arready) begin
          arvalid_n = 1'b0;
          araddr_n  = 32'h0;
          state_n   = RD_DATA;
        end
      end

      RD_DATA: begin
        // Error responses still deliver their data to the response FIFO.
        if (rvalid && rready) begin
          resp_write_en_n = 1'b1;
          resp_data_n     = rdata;
          rd_err_n        = |rresp;
          state_n         = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // FSM state and arbitration history; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge arest) begin
    if (arest) begin
      state          <= IDLE;
      last_was_write <= 1'b0;
    end else begin
      state          <= state_n;
      last_was_write <= last_was_write_n;
    end
  end

  // Registered AXI and FIFO-side outputs, all cleared by reset.
  always_ff @(posedge clk or posedge arest) begin
    if (arest) begin
      awaddr        <= 32'h0;
      awvalid       <= 1'b0;
      wdata         <= 32'h0;
      wvalid        <= 1'b0;
      bready        <= 1'b0;
      araddr        <= 32'h0;
      arvalid       <= 1'b0;
      wr_read_en    <= 1'b0;
      rd_read_en    <= 1'b0;
      resp_write_en <= 1'b0;
      resp_data     <= 32'h0;
      wr_err        <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      awaddr        <= awaddr_n;
      awvalid       <= awvalid_n;
      wdata         <= wdata_n;
      wvalid        <= wvalid_n;
      bready        <= bready_n;
      araddr        <= araddr_n;
      arvalid       <= arvalid_n;
      wr_read_en    <= wr_read_en_n;
      rd_read_en    <= rd_read_en_n;
      resp_write_en <= resp_write_en_n;
      resp_data     <= resp_data_n;
      wr_err        <= wr_err_n;
      rd_err        <= rd_err_n;
    end
  end

endmodule
